// File: rtl/pdp8_bus_pkg.sv
// Shared encodings for the PDP-8 nibble bus: beat classes, responder FSM states,
// nibble order and I/O status bit positions.
package pdp8_bus_pkg;

  localparam logic [7:0] LO_MASK   = 8'hC0;
  localparam logic [7:0] LO_VAL    = 8'h80;
  localparam logic [7:0] HI_MASK   = 8'hC0;
  localparam logic [7:0] HI_VAL    = 8'hC0;
  localparam logic [7:0] IO_MASK   = 8'hE8;
  localparam logic [7:0] IO_VAL    = 8'h60;
  localparam logic [7:0] DATA_MASK = 8'h80;
  localparam logic [7:0] DATA_VAL  = 8'h00;

  localparam int         W_BIT = 4;
  localparam logic [1:0] TT_D0 = 2'd0;
  localparam logic [1:0] TT_D1 = 2'd1;
  localparam logic [1:0] TT_D2 = 2'd2;

  localparam int RD_NIB0_LSB = 8;
  localparam int RD_NIB1_LSB = 4;
  localparam int RD_NIB2_LSB = 0;
  localparam int WR_NIB0_LSB = 0;
  localparam int WR_NIB1_LSB = 4;
  localparam int WR_NIB2_LSB = 8;

  localparam int STAT_READY = 0;
  localparam int STAT_SKIP  = 1;
  localparam int STAT_IRQ   = 2;

  typedef enum logic [2:0] {S_IDLE, S_WHI, S_WPOST, S_WD1, S_WD2} state_t;
  typedef enum logic [2:0] {B_LO, B_HI, B_IO, B_DATA, B_BAD} beat_t;

  // Beat index 2'b11 with bit 3 set is not a legal beat of any class.
  function automatic beat_t classify(input logic [7:0] b);
    if ((b & LO_MASK) == LO_VAL) return B_LO;
    if ((b & HI_MASK) == HI_VAL) return B_HI;
    if ((b & IO_MASK) == IO_VAL) return B_IO;
    if (((b & DATA_MASK) == DATA_VAL) && (b[6:5] != 2'b11)) return B_DATA;
    return B_BAD;
  endfunction

endpackage

// File: rtl/pdp8_bus_ram.sv
// Word RAM with synchronous read; the bus commit takes the write port over a host load.
module pdp8_bus_ram #(
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [11:0]          rd_data,
  input  logic                 bus_we,
  input  logic [ADDR_BITS-1:0] bus_addr,
  input  logic [11:0]          bus_data,
  input  logic                 load_valid,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [11:0]          load_data,
  output logic                 load_ready
);
  logic [11:0] mem [0:(1 << ADDR_BITS) - 1];

  assign load_ready = !bus_we;

  always_ff @(posedge clk) begin
    if (bus_we) mem[bus_addr] <= bus_data;
    else if (load_valid) mem[load_addr] <= load_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pdp8_bus_target.sv
// Far-end responder for the PDP-8 nibble bus: decodes CPU beats, serves RAM
// and one I/O device port, and accepts host preloads.
module pdp8_bus_target
  import pdp8_bus_pkg::*;
#(
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           bus_out,
  output logic [3:0]           bus_in,
  output logic [5:0]           io_sel,
  output logic [2:0]           io_fn,
  input  logic                 io_ready,
  input  logic                 io_skip,
  input  logic                 irq,
  input  logic [11:0]          io_rd_data,
  output logic                 io_rd_strobe,
  output logic                 io_wr_valid,
  output logic [11:0]          io_wr_data,
  input  logic                 load_valid,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [11:0]          load_data,
  output logic                 load_ready,
  output logic                 proto_err
);
  state_t               state, state_nx;
  beat_t                beat;
  logic                 w_bit;
  logic [1:0]           tt;
  logic [3:0]           nib;
  logic [5:0]           addr_lo;
  logic [ADDR_BITS-1:0] hi_addr, mem_addr;
  logic                 io_cycle, wr_txn;
  logic [11:0]          wr_acc, wr_word, io_word, ram_q, rd_word;
  logic                 err, rd_en, io_start, d0, d1, d2, commit, wr_fire;

  assign beat    = classify(bus_out);
  assign w_bit   = bus_out[W_BIT];
  assign tt      = bus_out[6:5];
  assign nib     = bus_out[3:0];
  assign hi_addr = ADDR_BITS'({bus_out[5:0], addr_lo});
  assign rd_word = io_cycle ? io_word : ram_q;
  assign commit  = d2 && wr_txn && !io_cycle && reset_n;
  assign wr_fire = d2 && wr_txn && io_cycle;

  always_comb begin
    wr_word = wr_acc;
    wr_word[WR_NIB2_LSB +: 4] = nib;
  end

  always_comb begin
    state_nx = state;
    err      = 1'b0;
    bus_in   = '0;
    rd_en    = 1'b0;
    io_start = 1'b0;
    d0       = 1'b0;
    d1       = 1'b0;
    d2       = 1'b0;
    if (beat == B_LO) begin
      state_nx = S_WHI;
      err      = (state != S_IDLE);
    end else begin
      state_nx = S_IDLE;
      unique case (state)
        S_WHI: begin
          if (beat == B_HI) begin
            state_nx = S_WPOST;
            rd_en    = 1'b1;
          end else err = 1'b1;
        end
        S_WPOST: begin
          if (beat == B_IO && !io_cycle) begin
            state_nx = S_WPOST;
            io_start = 1'b1;
            bus_in[STAT_READY] = io_ready;
            bus_in[STAT_SKIP]  = io_skip;
            bus_in[STAT_IRQ]   = irq;
          end else if (beat == B_DATA && tt == TT_D0) begin
            state_nx = S_WD1;
            d0       = 1'b1;
            if (!w_bit) bus_in = rd_word[RD_NIB0_LSB +: 4];
          end else err = 1'b1;
        end
        S_WD1: begin
          if (beat == B_DATA && tt == TT_D1 && w_bit == wr_txn) begin
            state_nx = S_WD2;
            d1       = 1'b1;
            if (!wr_txn) bus_in = rd_word[RD_NIB1_LSB +: 4];
          end else err = 1'b1;
        end
        S_WD2: begin
          if (beat == B_DATA && tt == TT_D2 && w_bit == wr_txn) begin
            d2 = 1'b1;
            if (!wr_txn) bus_in = rd_word[RD_NIB2_LSB +: 4];
          end else err = 1'b1;
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      io_cycle     <= 1'b0;
      wr_txn       <= 1'b0;
      io_sel       <= '0;
      io_fn        <= '0;
      io_wr_data   <= '0;
      io_rd_strobe <= 1'b0;
      io_wr_valid  <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state        <= state_nx;
      proto_err    <= err;
      io_rd_strobe <= io_start && !w_bit;
      io_wr_valid  <= wr_fire;
      if (beat == B_LO) io_cycle <= 1'b0;
      if (io_start) begin
        io_cycle <= 1'b1;
        io_sel   <= addr_lo;
        io_fn    <= bus_out[2:0];
      end
      if (d0) wr_txn <= w_bit;
      if (wr_fire) io_wr_data <= wr_word;
    end
  end

  // Datapath captures: address halves, device read word, write nibbles.
  always_ff @(posedge clk) begin
    if (beat == B_LO) addr_lo <= bus_out[5:0];
    if (rd_en) mem_addr <= hi_addr;
    if (io_start && !w_bit) io_word <= io_rd_data;
    if (d0) wr_acc[WR_NIB0_LSB +: 4] <= nib;
    if (d1) wr_acc[WR_NIB1_LSB +: 4] <= nib;
  end

  pdp8_bus_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk        (clk),
    .rd_en      (rd_en),
    .rd_addr    (hi_addr),
    .rd_data    (ram_q),
    .bus_we     (commit),
    .bus_addr   (mem_addr),
    .bus_data   (wr_word),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready)
  );

endmodule
